// File: rtl/locked_reg_write_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module  : locked_reg_write_ctrl_if
// Brief   : Request handshake and register write bus of the lockable config
//           register write controller.
// Revision: 1.0 - initial release
// ============================================================================
interface locked_reg_write_ctrl_if #(
  parameter int DATA_W = 16
);
  logic              req_valid;
  logic              req_ready;
  logic [DATA_W-1:0] req_data;
  logic              req_lock;
  logic [DATA_W-1:0] wr_data;
  logic              wr_strobe;
  logic              lock_out;

  // master: requester that also observes the register write port
  modport master (
    output req_valid, req_data, req_lock,
    input  req_ready, wr_data, wr_strobe, lock_out
  );

  // slave: the write controller
  modport slave (
    input  req_valid, req_data, req_lock,
    output req_ready, wr_data, wr_strobe, lock_out
  );
endinterface
`default_nettype wire

// File: rtl/locked_reg_write_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : locked_reg_write_ctrl
// Brief   : Queues config writes, applies the sticky lock policy and drives
//           spaced write strobes plus the Lock pulse into the config register.
// Revision: 1.0 - initial release
// ============================================================================
module locked_reg_write_ctrl #(
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int VIOL_W     = 8
) (
  input  wire logic                        Clk,
  input  wire logic                        resetn,
  locked_reg_write_ctrl_if.slave           bus,
  input  wire logic                        scan_mode,
  input  wire logic                        debug_unlocked,
  output logic                             locked,
  output logic                             viol_pulse,
  output logic [VIOL_W-1:0]                viol_count,
  output logic [$clog2(FIFO_DEPTH):0]      fifo_level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = DATA_W + 1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_STROBE = 3'd2;
  localparam logic [2:0] S_GAP    = 3'd3;
  localparam logic [2:0] S_DROP   = 3'd4;

  localparam logic [AW:0]       c_ptr_one  = {{AW{1'b0}}, 1'b1};
  localparam logic [VIOL_W-1:0] c_viol_one = {{(VIOL_W-1){1'b0}}, 1'b1};
  localparam logic [VIOL_W-1:0] c_viol_max = {VIOL_W{1'b1}};

  logic [EW-1:0]     r_fifo_mem [FIFO_DEPTH];
  logic [AW:0]       r_wr_ptr;
  logic [AW:0]       r_rd_ptr;
  logic              r_ready_en;
  logic [2:0]        r_state;
  logic [DATA_W-1:0] r_wr_data;
  logic              r_entry_lock;
  logic              r_locked;
  logic [VIOL_W-1:0] r_viol_count;

  logic              w_empty;
  logic              w_full;
  logic              w_req_ready;
  logic              w_push;
  logic              w_pop;
  logic [EW-1:0]     w_head;
  logic              w_bypass_ok;
  logic              w_grant;

  // Full when the indices match but the wrap bits differ.
  assign w_empty     = (r_wr_ptr == r_rd_ptr);
  assign w_full      = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  // r_ready_en keeps req_ready low while reset is asserted.
  assign w_req_ready = r_ready_en & ~w_full;
  assign w_push      = bus.req_valid & w_req_ready;
  assign w_pop       = (r_state == S_IDLE) & ~w_empty;
  assign w_head      = r_fifo_mem[r_rd_ptr[AW-1:0]];
  assign w_bypass_ok = debug_unlocked & ~scan_mode;
  assign w_grant     = w_bypass_ok | ~r_locked;

  always_ff @(posedge Clk) begin
    if (w_push) begin
      r_fifo_mem[r_wr_ptr[AW-1:0]] <= {bus.req_lock, bus.req_data};
    end
  end

  always_ff @(posedge Clk or negedge resetn) begin
    if (!resetn) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_ready_en <= 1'b0;
    end else begin
      r_ready_en <= 1'b1;
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_ptr_one;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_ptr_one;
      end
    end
  end

  // wr_data is captured at pop so it leads the strobe by one full cycle;
  // the violation count moves on entry to DROP so it is current during the pulse.
  always_ff @(posedge Clk or negedge resetn) begin
    if (!resetn) begin
      r_state      <= S_IDLE;
      r_wr_data    <= '0;
      r_entry_lock <= 1'b0;
      r_locked     <= 1'b0;
      r_viol_count <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            if (w_grant) begin
              r_wr_data    <= w_head[DATA_W-1:0];
              r_entry_lock <= w_head[DATA_W];
              r_state      <= S_LOAD;
            end else begin
              if (r_viol_count != c_viol_max) begin
                r_viol_count <= r_viol_count + c_viol_one;
              end
              r_state <= S_DROP;
            end
          end
        end
        S_LOAD:   r_state <= S_STROBE;
        S_STROBE: r_state <= S_GAP;
        S_GAP: begin
          if (r_entry_lock) begin
            r_locked <= 1'b1;
          end
          r_state <= S_IDLE;
        end
        S_DROP:   r_state <= S_IDLE;
        default:  r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.req_ready = w_req_ready;
  assign bus.wr_data   = r_wr_data;
  assign bus.wr_strobe = (r_state == S_STROBE);
  assign bus.lock_out  = (r_state == S_GAP) & r_entry_lock;
  assign locked        = r_locked;
  assign viol_pulse    = (r_state == S_DROP);
  assign viol_count    = r_viol_count;
  assign fifo_level    = r_wr_ptr - r_rd_ptr;

endmodule
`default_nettype wire
